// File: rtl/data_sram_responder.sv
// Data-memory responder for the MEM stage: word-organised, byte-lane-writable RAM
// with a configurable number of wait states, a one-cycle ready pulse and a stall.
module data_sram_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        stall_o
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_we;
    logic [AW-1:0]  r_idx;
    logic [3:0]     r_sel;
    logic [31:0]    r_wdata;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_capture;
    logic           w_access;
    logic           w_acc_we;
    logic [AW-1:0]  w_acc_idx;
    logic [3:0]     w_acc_sel;
    logic [31:0]    w_acc_wdata;
    logic           w_unused_addr;

    // With zero wait states the access happens on the capture edge, so the
    // live request inputs are used instead of the (not yet loaded) latches.
    always_comb begin
        w_capture   = (r_state == IDLE) && ce_i;
        w_access    = rst && ((w_capture && (WAIT_CYCLES == 0)) ||
                              ((r_state == WAIT) && (r_cnt == 4'd0)));
        w_acc_we    = r_we;
        w_acc_idx   = r_idx;
        w_acc_sel   = r_sel;
        w_acc_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_acc_we    = we_i;
            w_acc_idx   = addr_i[AW+1:2];
            w_acc_sel   = sel_i;
            w_acc_wdata = data_i;
        end
    end

    assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (w_access && w_acc_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_sel[i]) begin
                    r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_sel   <= 4'd0;
            r_wdata <= 32'd0;
            ready_o <= 1'b0;
            data_o  <= 32'd0;
        end else begin
            ready_o <= 1'b0;
            if (w_access && !w_acc_we) begin
                data_o <= r_mem[w_acc_idx];
            end
            case (r_state)
                IDLE: begin
                    if (ce_i) begin
                        r_we    <= we_i;
                        r_idx   <= addr_i[AW+1:2];
                        r_sel   <= sel_i;
                        r_wdata <= data_i;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= RESP;
                            ready_o <= 1'b1;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                        ready_o <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall_o = ce_i & ~ready_o;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (1, 0 and 3 wait states) driven
// by directed scenarios and random traffic, checked against a word/lane memory model.
module tb_data_sram_responder;

    localparam int          DEPTH = 1024;
    localparam logic [11:0] WCS   = {4'd3, 4'd0, 4'd1};

    logic        clk = 1'b0;
    logic        rst;
    logic        ce   [3];
    logic        we   [3];
    logic [31:0] addr [3];
    logic [3:0]  sel  [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic        rdy  [3];
    logic        stl  [3];

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl      [3][DEPTH];
    bit          known    [3][DEPTH];
    logic [31:0] lastRd   [3];
    bit          lastKnown[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        data_sram_responder #(
            .DEPTH_WORDS(DEPTH),
            .WAIT_CYCLES(int'(WCS[g*4 +: 4]))
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .ce_i   (ce[g]),
            .we_i   (we[g]),
            .addr_i (addr[g]),
            .sel_i  (sel[g]),
            .data_i (din[g]),
            .data_o (dout[g]),
            .ready_o(rdy[g]),
            .stall_o(stl[g])
        );
    end

    function automatic int waitOf(input int d);
        return int'(WCS[d*4 +: 4]);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete request on DUT d; checks latency, stall length and data_o.
    task automatic applyStimulus(input int d, input bit w, input logic [31:0] a,
                                 input logic [3:0] s, input logic [31:0] dat, input bit scramble);
        int n;
        int stallHi;
        int idx;
        if (rdy[d]) begin
            @(posedge clk);
            #1;
            checkOutput("pulse_len", 32'(rdy[d]), 32'd0);
        end
        ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; din[d] = dat;
        #1;
        n = 0;
        stallHi = int'(stl[d]);
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!rdy[d]) begin
                stallHi += int'(stl[d]);
                if (scramble) begin
                    we[d] = 1'($urandom); addr[d] = $urandom; sel[d] = 4'($urandom); din[d] = $urandom;
                end
            end
        end while (!rdy[d] && n < 40);
        checkOutput("latency", 32'(n), 32'(waitOf(d) + 1));
        checkOutput("stall_cycles", 32'(stallHi), 32'(waitOf(d) + 1));
        checkOutput("stall_at_ready", 32'(stl[d]), 32'd0);
        idx = int'((a >> 2) % DEPTH);
        if (w) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) mdl[d][idx][8*i +: 8] = dat[8*i +: 8];
            end
            if (s == 4'hF) known[d][idx] = 1'b1;
            if (lastKnown[d]) checkOutput("hold_on_write", dout[d], lastRd[d]);
        end else begin
            lastKnown[d] = known[d][idx];
            lastRd[d]    = mdl[d][idx];
            if (known[d][idx]) checkOutput("read_data", dout[d], mdl[d][idx]);
        end
        ce[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        int d;
        for (int k = 0; k < 3; k++) begin
            ce[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; sel[k] = 4'd0; din[k] = 32'd0;
            lastRd[k] = 32'd0; lastKnown[k] = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
                mdl[k][j] = 32'd0; known[k][j] = 1'b0;
            end
        end

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("rst_ready", 32'(rdy[k]), 32'd0);
            checkOutput("rst_data", dout[k], 32'd0);
        end
        rst = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                checkOutput("idle_ready", 32'(rdy[k]), 32'd0);
                checkOutput("idle_data", dout[k], 32'd0);
                checkOutput("idle_stall", 32'(stl[k]), 32'd0);
            end
        end

        applyStimulus(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0);
        applyStimulus(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b0);
        checkOutput("word_rd", dout[0], 32'hDEADBEEF);

        applyStimulus(0, 1'b1, 32'h20, 4'b1111, 32'h11223344, 1'b0);
        applyStimulus(0, 1'b1, 32'h20, 4'b0100, 32'hAAAAAAAA, 1'b0);
        applyStimulus(0, 1'b0, 32'h20, 4'b0000, 32'h0, 1'b0);
        checkOutput("byte_merge", dout[0], 32'h11AA3344);

        applyStimulus(0, 1'b1, 32'h20, 4'b0011, 32'h55665566, 1'b0);
        applyStimulus(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 1'b0);
        checkOutput("null_sel_ready", 32'(rdy[0]), 32'd1);
        applyStimulus(0, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b0);
        checkOutput("half_merge", dout[0], 32'h11AA5566);

        applyStimulus(1, 1'b1, 32'h1000, 4'b1111, 32'h12345678, 1'b0);
        applyStimulus(1, 1'b0, 32'h0000, 4'b1111, 32'h0, 1'b0);
        checkOutput("alias_rd", dout[1], 32'h12345678);

        applyStimulus(2, 1'b1, 32'h30, 4'b1111, 32'h00000000, 1'b0);
        @(posedge clk);
        #1;
        ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h30; sel[2] = 4'hF; din[2] = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(rdy[2]), 32'd0);
        checkOutput("abort_data", dout[2], 32'd0);
        ce[2] = 1'b0;
        #1;
        checkOutput("abort_stall", 32'(stl[2]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            lastRd[k] = 32'd0; lastKnown[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(2, 1'b0, 32'h30, 4'b1111, 32'h0, 1'b0);
        checkOutput("abort_discard", dout[2], 32'd0);

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 16; j++) begin
                applyStimulus(k, 1'b1, 32'(j * 4), 4'hF, $urandom, 1'b0);
            end
        end
        for (int it = 0; it < 300; it++) begin
            d  = int'($urandom_range(0, 2));
            ra = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
            applyStimulus(d, 1'($urandom), ra, 4'($urandom), $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder end of the MEM-stage data-memory interface. Accepts the stage's chip-enable / write-enable / address / byte-select / write-data request and services it against an internal word-organised, byte-lane-writable RAM with configurable wait states.
- Returns the full 32-bit read word plus a one-cycle ready pulse, and a stall to hold the pipeline.
- Sits between the MEM stage and the data-side memory; replaces a zero-latency combinational data RAM.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- WAIT_CYCLES, 1, extra cycles between request capture and access; range 0 to 15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-low (rst==0 resets).
- ce_i  input  1  request valid (chip enable) from MEM stage.
- we_i  input  1  1=write, 0=read; meaningful only with ce_i.
- addr_i  input  32  byte address; bits [1:0] are ignored (the lane is carried by sel_i).
- sel_i  input  4  byte-lane select; bit3 = bits[31:24] = byte offset 00 (big-endian lanes).
- data_i  input  32  write data, already lane-replicated by requester.
- data_o  output  32  read word, full 32 bits regardless of sel_i; requester extracts and extends.
- ready_o  output  1  one-cycle pulse: access complete, data_o valid for reads.
- stall_o  output  1  combinational: ce_i & ~ready_o; requester holds request while high.

Behaviour:
- Reset (rst==0, asynchronous):
  - state=IDLE, ready_o=0, data_o=0, wait counter=0, latched request cleared.
  - RAM contents are not cleared.
  - Reset mid-access aborts the access; a pending write not yet committed is discarded.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, ce_i=1: latch we_i, word index, sel_i, data_i.
    - If WAIT_CYCLES=0: perform the access on this edge and go to RESP.
    - Otherwise: load counter=WAIT_CYCLES-1 and go to WAIT.
  - IDLE, ce_i=0: stay in IDLE; ready_o=0.
  - WAIT, counter!=0: decrement the counter.
  - WAIT, counter==0: perform the access on this edge and go to RESP.
  - RESP: ready_o=1 for exactly this cycle; go to IDLE unconditionally.
- Access:
  - Write: for each i with sel_i[i]=1, RAM byte lane i takes data_i lane i; other lanes are unchanged. sel=0000 writes nothing but still completes with a ready pulse. data_o is unchanged on writes.
  - Read: data_o takes RAM[index] (full word). data_o holds this value until the next read completes or reset.
- Latency: a request captured at edge T gives ready_o=1 in the cycle after edge T+WAIT_CYCLES. Total occupancy is WAIT_CYCLES+2 cycles per request, including the IDLE capture cycle.
- Request inputs are ignored outside IDLE; latched values are used, so input changes mid-access have no effect.
- Back-to-back requests:
  - The cycle after RESP is IDLE and may capture the next request immediately.
  - The held request is not re-captured, because the requester advances on ready_o.
- Read-after-write to the same word returns the newly merged data; no bypass is needed because accesses are serialised.
- A write with the requester's exception squash (we_i deasserted by requester) is handled as a read. The responder needs no exception knowledge.
- stall_o is purely combinational and has no reset dependency beyond ready_o.

Test Plan:
- Reset then idle (WAIT_CYCLES=1):
  - Hold rst=0 for 3 cycles, then release with ce_i=0 for 5 cycles.
  - Required: ready_o=0, data_o=0, stall_o=0 throughout.
- Word write/read:
  - Write addr 0x10, sel 1111, data 0xDEADBEEF, then read addr 0x10.
  - Required: ready_o in cycle 3 after each capture; read data_o=0xDEADBEEF; stall_o high for 2 cycles per request.
- Byte merge:
  - Preload 0x11223344 at 0x20, write sel 0100 data 0xAAAAAAAA, then read.
  - Required: data_o=0x11AA3344.
- Half-word and null select:
  - Write sel 0011 data 0x55665566 to 0x20, then write sel 0000 data 0xFFFFFFFF.
  - Required: read gives 0x11AA5566; the sel=0000 write still produces a ready pulse.
- Aliasing and WAIT_CYCLES=0:
  - With DEPTH_WORDS=1024, write 0x12345678 to 0x1000, then read 0x0000.
  - Required: read returns 0x12345678; ready_o exactly one cycle after capture.
- Reset mid-access (WAIT_CYCLES=3):
  - Capture a write of 0xCAFEF00D to 0x30 (prior contents 0), pull rst low during WAIT.
  - Required: outputs return to reset values immediately; a later read of 0x30 returns 0.
